// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: FSM state type and counter saturation constant shared by freq_meter
package freq_meter_pkg;

    typedef enum logic [2:0] {IDLE, ARM, HIGH, LOW, DONE} state_e;

    // All-ones pattern; the top slices off its own CNT_W bits (CNT_W up to 64)
    localparam logic [63:0] SAT_VAL = '1;

endpackage

// File: rtl/freq_meter_sync.sv
// freq_meter_sync: multi-flop synchronizer bringing sig_i into the clk_in domain
module freq_meter_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] ff_q;

    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) ff_q <= '0;
        else        ff_q <= {ff_q[SYNC_STAGES-2:0], sig_i};

    assign sync_o = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/freq_meter.sv
// freq_meter: measures high/low time of sig_in in clk_in cycles.
// Optional FREQ_METER_DEBOUNCE_EN: accept a level change only after it is stable
// for 2 consecutive cycles (adds 2 cycles of edge latency, counts unchanged).
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] SAT = SAT_VAL[CNT_W-1:0];

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cont_q;
    logic             ovf_q;
    logic             sync_s;
    logic             lvl_q;
    logic             lvl_d;
    logic             sat_hit;
    logic             rise;
    logic             fall;

    freq_meter_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .sig_i  (sig_in),
        .sync_o (sync_s)
    );

`ifdef FREQ_METER_DEBOUNCE_EN
    logic [1:0] dly_q;

    // delay line: a level is accepted once two successive samples agree
    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) dly_q <= '0;
        else        dly_q <= {dly_q[0], sync_s};

    assign lvl_d = (dly_q[0] == dly_q[1]) ? dly_q[1] : lvl_q;
`else
    assign lvl_d = sync_s;
`endif

    // lvl_q is the history flop; edges are the difference between new and old level
    assign rise    = lvl_d & ~lvl_q;
    assign fall    = ~lvl_d & lvl_q;
    assign sat_hit = (cnt_q == SAT);
    assign cnt_d   = sat_hit ? cnt_q : cnt_q + 1'b1;

    // measurement FSM with registered results and status outputs
    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cont_q     <= 1'b0;
            ovf_q      <= 1'b0;
            lvl_q      <= 1'b0;
            busy       <= 1'b0;
            meas_valid <= 1'b0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            period     <= '0;
            ovf        <= 1'b0;
        end else begin
            lvl_q      <= lvl_d;
            meas_valid <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= ARM;
                    cont_q  <= cont;
                    busy    <= 1'b1;
                end
                ARM: if (rise) begin
                    state_q <= HIGH;
                    cnt_q   <= CNT_W'(1);
                    ovf_q   <= 1'b0;
                end
                HIGH: if (fall) begin
                    high_cnt <= cnt_q;
                    cnt_q    <= CNT_W'(1);
                    state_q  <= LOW;
                end else begin
                    cnt_q <= cnt_d;
                    ovf_q <= ovf_q | sat_hit;
                end
                LOW: if (rise) begin
                    low_cnt    <= cnt_q;
                    period     <= {1'b0, high_cnt} + {1'b0, cnt_q};
                    ovf        <= ovf_q;
                    meas_valid <= 1'b1;
                    state_q    <= DONE;
                end else begin
                    cnt_q <= cnt_d;
                    ovf_q <= ovf_q | sat_hit;
                end
                DONE: if (cont_q) begin
                    state_q <= HIGH;
                    cnt_q   <= CNT_W'(2);
                    ovf_q   <= 1'b0;
                end else begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: randomized scoreboard bench for freq_meter (CNT_W=4 to reach saturation)
module tb_freq_meter;

    localparam int W   = 4;
    localparam int SAT = (1 << W) - 1;

    typedef struct packed {
        logic [W-1:0] h;
        logic [W-1:0] l;
        logic [W:0]   p;
        logic         o;
    } res_t;

    logic         clk_in = 1'b0;
    logic         rst_n  = 1'b0;
    logic         sig_in = 1'b0;
    logic         start  = 1'b0;
    logic         cont   = 1'b0;
    logic         busy;
    logic         meas_valid;
    logic [W-1:0] high_cnt;
    logic [W-1:0] low_cnt;
    logic [W:0]   period;
    logic         ovf;

    res_t exp_q[$];
    res_t last;
    res_t mon_got;
    res_t mon_exp;
    int   tests = 0;
    int   fails = 0;

    always #5 clk_in = ~clk_in;

    freq_meter #(.CNT_W(W), .SYNC_STAGES(3)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .start      (start),
        .cont       (cont),
        .busy       (busy),
        .meas_valid (meas_valid),
        .high_cnt   (high_cnt),
        .low_cnt    (low_cnt),
        .period     (period),
        .ovf        (ovf)
    );

    // reference: counts clip at the counter maximum, ovf flags any clipping
    function automatic res_t model(int h, int l);
        int hc = (h > SAT) ? SAT : h;
        int lc = (l > SAT) ? SAT : l;
        int pc = hc + lc;
        res_t r;
        r.h = hc[W-1:0];
        r.l = lc[W-1:0];
        r.p = pc[W:0];
        r.o = (h > SAT) || (l > SAT);
        return r;
    endfunction

    // monitor: every result pulse must match the oldest expected entry
    always @(negedge clk_in) begin
        if (rst_n && meas_valid) begin
            mon_got = {high_cnt, low_cnt, period, ovf};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_meas got h=%0d l=%0d p=%0d o=%0d, none expected",
                         mon_got.h, mon_got.l, mon_got.p, mon_got.o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    fails++;
                    $display("FAIL meas got h=%0d l=%0d p=%0d o=%0d exp h=%0d l=%0d p=%0d o=%0d",
                             mon_got.h, mon_got.l, mon_got.p, mon_got.o,
                             mon_exp.h, mon_exp.l, mon_exp.p, mon_exp.o);
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic hold(logic v, int n);
        sig_in = v;
        cyc(n);
    endtask

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic wait_idle(string name);
        int k = 0;
        while (busy && k < 200) begin
            cyc(1);
            k++;
        end
        check(name, 64'(busy), 64'd0);
        check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    // one-shot measurement of a high h / low l waveform, optionally re-pulsing start mid-high
    task automatic single(int h, int l, bit restart);
        hold(1'b0, 6);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("busy_armed", 64'(busy), 64'd1);
        hold(1'b0, 2);
        last = model(h, l);
        exp_q.push_back(last);
        if (restart) begin
            hold(1'b1, h - 1);
            start = 1'b1;
            cont  = 1'b1;
            hold(1'b1, 1);
            start = 1'b0;
            cont  = 1'b0;
        end else begin
            hold(1'b1, h);
        end
        hold(1'b0, l);
        hold(1'b1, 4);
        hold(1'b0, 2);
        wait_idle("idle_after_meas");
        check("results_hold", 64'({high_cnt, low_cnt, period, ovf}), 64'(last));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int h;
        int l;
        cyc(3);
        check("reset_state", 64'({busy, meas_valid, high_cnt, low_cnt, period, ovf}), 64'd0);
        rst_n = 1'b1;
        cyc(2);

        single(5, 5, 1'b0);
        single(40, 2, 1'b0);
        single(3, 3, 1'b0);
        single(6, 4, 1'b1);
        single(1, 1, 1'b0);
        single(15, 16, 1'b0);
        for (int i = 0; i < 8; i++) begin
            h = int'($urandom_range(20, 1));
            l = int'($urandom_range(20, 1));
            single(h, l, 1'b0);
        end

        hold(1'b0, 6);
        start = 1'b1;
        cont  = 1'b1;
        cyc(1);
        start = 1'b0;
        cont  = 1'b0;
        hold(1'b0, 2);
        for (int i = 0; i < 6; i++) begin
            h = (i < 3) ? 3 : int'($urandom_range(12, 2));
            l = (i < 3) ? 7 : int'($urandom_range(12, 2));
            exp_q.push_back(model(h, l));
            hold(1'b1, h);
            hold(1'b0, l);
        end
        hold(1'b1, 6);
        check("busy_cont", 64'(busy), 64'd1);
        check("cont_drain", 64'(exp_q.size()), 64'd0);
        rst_n = 1'b0;
        #2;
        check("reset_mid_high", 64'({busy, meas_valid, high_cnt, low_cnt, period, ovf}), 64'd0);
        cyc(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hold(1'b0, 4);
            hold(1'b1, 4);
        end
        check("no_rearm_after_reset", 64'({busy, meas_valid}), 64'd0);

        hold(1'b0, 6);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        hold(1'b0, 2);
`ifdef FREQ_METER_DEBOUNCE_EN
        exp_q.push_back(model(6, 6));
`else
        exp_q.push_back(model(2, 1));
`endif
        hold(1'b1, 2);
        hold(1'b0, 1);
        hold(1'b1, 3);
        hold(1'b0, 6);
        hold(1'b1, 5);
        hold(1'b0, 2);
        wait_idle("glitch_meas");

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
